// File: rtl/pipelined_prefix_tree.sv
// Pipelined Sklansky parallel-prefix tree over 2-bit {g,p} groups with a per-beat mode
// (full prefix or Brent-Kung up-sweep) and a valid/ready handshake that keeps full throughput.
module pipelined_prefix_tree #(
  parameter int NUM_GROUPS       = 32,
  parameter int LEVELS_PER_STAGE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [2*NUM_GROUPS-1:0] q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic [2*NUM_GROUPS-1:0] r
);

  localparam int W      = 2 * NUM_GROUPS;
  localparam int LEVELS = $clog2(NUM_GROUPS);
  localparam int LAT    = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  typedef logic [W-1:0] data_t;

  // One Sklansky level k. Group i combines with the top of the lower half of its
  // 2^(k+1) block; in up-sweep mode only the block's top group combines, which is
  // exactly the Brent-Kung reduce node, and its partner is then i - 2^k.
  function automatic data_t prefix_level(input data_t d, input int k, input logic up_only);
    data_t res;
    res = d;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      int j;
      j = ((i >> (k + 1)) << (k + 1)) + (1 << k) - 1;
      if ((((i >> k) & 1) == 1) && (!up_only || (((i + 1) & ((2 << k) - 1)) == 0))) begin
        res[2*i+1] = d[2*i+1] | (d[2*i] & d[2*j+1]);
        res[2*i]   = d[2*i] & d[2*j];
      end
    end
    return res;
  endfunction

  logic [LAT-1:0] w_valid;
  logic [LAT-1:0] w_mode;
  logic [LAT-1:0] w_load;
  data_t          w_data [LAT];

  // A slice may load when any slice from it to the output is empty, or the output
  // is being drained; this is what removes bubbles under back-pressure.
  always_comb begin
    logic all_full;
    // NOTE: every variable written in always_comb gets a value before any branch,
    // otherwise synthesis infers a latch to hold the old value.
    all_full = 1'b1;
    w_load   = '0;
    for (int s = LAT - 1; s >= 0; s--) begin
      all_full  = all_full & w_valid[s];
      w_load[s] = out_ready | ~all_full;
    end
  end

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int LO = s * LEVELS_PER_STAGE;
    localparam int HI = (LO + LEVELS_PER_STAGE > LEVELS) ? LEVELS : LO + LEVELS_PER_STAGE;

    data_t w_in;
    data_t w_out;
    logic  w_in_valid;
    logic  w_in_mode;
    data_t r_data;
    logic  r_valid;
    logic  r_mode;

    if (s == 0) begin : g_head
      assign w_in       = q;
      assign w_in_valid = in_valid;
      assign w_in_mode  = in_mode;
    end else begin : g_body
      assign w_in       = w_data[s-1];
      assign w_in_valid = w_valid[s-1];
      assign w_in_mode  = w_mode[s-1];
    end

    always_comb begin
      w_out = w_in;
      for (int k = LO; k < HI; k++) begin
        w_out = prefix_level(w_out, k, w_in_mode);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        // NOTE: the data registers are reset too, because r must read zero out of
        // reset; pure datapath storage would normally be left unreset.
        r_valid <= 1'b0;
        r_mode  <= 1'b0;
        r_data  <= '0;
      end else if (w_load[s]) begin
        // NOTE: non-blocking assignments so every slice samples its upstream
        // neighbour's pre-edge value; blocking here would let a beat skip slices.
        r_valid <= w_in_valid;
        if (w_in_valid) begin
          r_data <= w_out;
          r_mode <= w_in_mode;
        end
      end
    end

    assign w_valid[s] = r_valid;
    assign w_mode[s]  = r_mode;
    assign w_data[s]  = r_data;
  end

  assign in_ready  = w_load[0];
  assign out_valid = w_valid[LAT-1];
  assign out_mode  = w_mode[LAT-1];
  assign r         = w_data[LAT-1];

endmodule

// File: tb/tb_pipelined_prefix_tree.sv
// Scoreboard bench for pipelined_prefix_tree: an 8-group LAT=3 instance for directed
// latency/stall/reset checks and a 32-group, two-levels-per-slice instance for random traffic.
module tb_pipelined_prefix_tree;

  localparam int LAT8 = 3;

  typedef struct {
    logic        mode;
    logic [63:0] r;
  } exp_t;

  logic        clk;
  logic        reset;

  logic        in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_mode8;
  logic [15:0] q8, r8;
  logic        in_valid32, in_ready32, in_mode32, out_valid32, out_ready32, out_mode32;
  logic [63:0] q32, r32;

  exp_t sb8[$];
  exp_t sb32[$];
  exp_t e8, e32;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pops8   = 0;
  int   pops32  = 0;

  pipelined_prefix_tree #(.NUM_GROUPS(8), .LEVELS_PER_STAGE(1)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_mode(in_mode8), .q(q8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_mode(out_mode8), .r(r8)
  );

  pipelined_prefix_tree #(.NUM_GROUPS(32), .LEVELS_PER_STAGE(2)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_mode(in_mode32), .q(q32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_mode(out_mode32), .r(r32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial fold straight from the operator definition, independent of any tree shape.
  function automatic logic [63:0] ref_prefix(input logic [63:0] qv, input int n, input logic up);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < n; i++) begin
      int   lo;
      logic g, p;
      lo = up ? (i - ((i + 1) & -(i + 1)) + 1) : 0;
      g  = qv[2*lo+1];
      p  = qv[2*lo];
      for (int j = lo + 1; j <= i; j++) begin
        g = qv[2*j+1] | (qv[2*j] & g);
        p = qv[2*j] & p;
      end
      res[2*i+1] = g;
      res[2*i]   = p;
    end
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are decided by values stable from posedge+1 to the next posedge,
  // so the negedge sees exactly what the coming edge will transfer.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid8 && out_ready8) begin
        if (sb8.size() == 0) check("sb8_extra", 64'd1, 64'd0);
        else begin
          e8 = sb8.pop_front();
          check("sb8_r", {48'd0, r8}, e8.r);
          check("sb8_mode", {63'd0, out_mode8}, {63'd0, e8.mode});
          pops8++;
        end
      end
      if (in_valid8 && in_ready8) begin
        e8.mode = in_mode8;
        e8.r    = ref_prefix({48'd0, q8}, 8, in_mode8);
        sb8.push_back(e8);
      end
      if (out_valid32 && out_ready32) begin
        if (sb32.size() == 0) check("sb32_extra", 64'd1, 64'd0);
        else begin
          e32 = sb32.pop_front();
          check("sb32_r", r32, e32.r);
          check("sb32_mode", {63'd0, out_mode32}, {63'd0, e32.mode});
          pops32++;
        end
      end
      if (in_valid32 && in_ready32) begin
        e32.mode = in_mode32;
        e32.r    = ref_prefix(q32, 32, in_mode32);
        sb32.push_back(e32);
      end
    end
  end

  task automatic send8(input string tag, input logic mode, input logic [15:0] qv,
                       input logic [15:0] exp_r);
    in_valid8 = 1'b1;
    in_mode8  = mode;
    q8        = qv;
    check({tag, "_in_ready"}, {63'd0, in_ready8}, 64'd1);
    step();
    in_valid8 = 1'b0;
    for (int c = 1; c < LAT8; c++) begin
      check({tag, "_early"}, {63'd0, out_valid8}, 64'd0);
      step();
    end
    check({tag, "_valid"}, {63'd0, out_valid8}, 64'd1);
    check({tag, "_r"}, {48'd0, r8}, {48'd0, exp_r});
    check({tag, "_mode"}, {63'd0, out_mode8}, {63'd0, mode});
  endtask

  initial begin
    int          pre;
    int          acc;
    int          sent;
    int          cycles;
    logic        fire;
    logic        have_snap;
    logic [15:0] snap;

    reset      = 1'b0;
    in_valid8  = 1'b0; in_mode8  = 1'b0; q8  = '0; out_ready8  = 1'b1;
    in_valid32 = 1'b0; in_mode32 = 1'b0; q32 = '0; out_ready32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid8}, 64'd0);
    check("rst_r", {48'd0, r8}, 64'd0);
    check("rst_out_mode", {63'd0, out_mode8}, 64'd0);
    check("rst_r32", r32, 64'd0);
    reset = 1'b1;
    check("rst_in_ready", {63'd0, in_ready8}, 64'd1);

    send8("t1_full", 1'b0, 16'h5556, 16'hAAAA);
    send8("t2_up", 1'b1, 16'h5556, 16'h959A);
    send8("t3_prop", 1'b0, 16'h5555, 16'h5555);
    send8("t3_zero", 1'b0, 16'h0000, 16'h0000);
    send8("t3_up_prop", 1'b1, 16'h5555, 16'h5555);
    step();

    // Back-to-back stream with alternating modes
    pre = pops8;
    for (int b = 0; b < 6; b++) begin
      in_valid8 = 1'b1;
      in_mode8  = (b % 2) != 0;
      q8        = 16'($urandom);
      check("t4_in_ready", {63'd0, in_ready8}, 64'd1);
      step();
    end
    in_valid8 = 1'b0;
    repeat (LAT8 + 1) step();
    check("t4_count", 64'(pops8 - pre), 64'd6);

    // Back-pressure: output blocked while four beats are offered
    out_ready8 = 1'b0;
    pre        = pops8;
    acc        = 0;
    have_snap  = 1'b0;
    snap       = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid8 = 1'b1;
      in_mode8  = (acc % 2) != 0;
      q8        = 16'(16'h1357 * (acc + 1));
      #1;
      if (out_valid8) begin
        if (have_snap) check("t5_r_stable", {48'd0, r8}, {48'd0, snap});
        else begin
          snap      = r8;
          have_snap = 1'b1;
        end
      end
      if (in_ready8) acc++;
      step();
    end
    check("t5_accepted", 64'(acc), 64'd3);
    check("t5_in_ready", {63'd0, in_ready8}, 64'd0);
    check("t5_out_valid", {63'd0, out_valid8}, 64'd1);
    check("t5_r_held", {48'd0, r8}, {48'd0, snap});
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    repeat (LAT8 + 1) step();
    check("t5_drained", 64'(pops8 - pre), 64'd3);

    // Reset with two beats in flight
    for (int b = 0; b < 2; b++) begin
      in_valid8 = 1'b1;
      in_mode8  = 1'b0;
      q8        = 16'hFFFF;
      step();
    end
    in_valid8 = 1'b0;
    reset     = 1'b0;
    #1;
    check("t6_out_valid", {63'd0, out_valid8}, 64'd0);
    check("t6_r", {48'd0, r8}, 64'd0);
    check("t6_out_mode", {63'd0, out_mode8}, 64'd0);
    sb8.delete();
    sb32.delete();
    step();
    step();
    reset = 1'b1;
    check("t6_in_ready", {63'd0, in_ready8}, 64'd1);
    for (int c = 0; c < LAT8 + 3; c++) begin
      step();
      check("t6_no_stale", {63'd0, out_valid8}, 64'd0);
    end

    // Random traffic with random back-pressure on the 32-group instance
    sent   = 0;
    cycles = 0;
    while (sent < 1000 && cycles < 20000) begin
      if (!in_valid32 && ($urandom_range(3) != 0)) begin
        in_valid32 = 1'b1;
        q32        = {$urandom, $urandom};
        in_mode32  = 1'($urandom_range(1));
      end
      out_ready32 = ($urandom_range(3) != 0);
      #1;
      fire = in_valid32 && in_ready32;
      step();
      if (fire) begin
        sent++;
        in_valid32 = 1'b0;
      end
      cycles++;
    end
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    for (int c = 0; c < 50 && sb32.size() != 0; c++) step();
    check("r32_sent", 64'(sent), 64'd1000);
    check("r32_drain", 64'(sb32.size()), 64'd0);
    check("r32_popped", 64'(pops32), 64'd1000);
    check("drain8", 64'(sb8.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
